// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if
// Bundles every non-clock signal between the multi-cycle control unit and
// the rest of the core (instruction/data memory handshakes, datapath
// controls, mul/div handshake and debug state).
//   master : the control unit (drives o_*, samples i_*)
//   slave  : datapath / memory side (drives i_*, samples o_*)
interface multicycle_control_unit_if #(
    parameter int ALU_OP_WIDTH = 4
);
    logic [31:0]             i_instr;
    logic                    i_imem_ready;
    logic                    i_dmem_ready;
    logic                    i_branch_taken;
    logic                    i_md_done;
    logic                    o_imem_req;
    logic                    o_ir_wen;
    logic                    o_pc_wen;
    logic [1:0]              o_pc_sel;
    logic                    o_reg_wen;
    logic                    o_alu_src1;
    logic                    o_alu_src2;
    logic [ALU_OP_WIDTH-1:0] o_alu_op;
    logic                    o_dmem_ren;
    logic                    o_dmem_wen;
    logic [2:0]              o_wb_mux;
    logic                    o_md_start;
    logic [2:0]              o_md_op;
    logic                    o_halt;
    logic                    o_illegal;
    logic                    o_retire;
    logic [2:0]              o_state;

    modport master (
        input  i_instr, i_imem_ready, i_dmem_ready, i_branch_taken, i_md_done,
        output o_imem_req, o_ir_wen, o_pc_wen, o_pc_sel, o_reg_wen,
               o_alu_src1, o_alu_src2, o_alu_op, o_dmem_ren, o_dmem_wen,
               o_wb_mux, o_md_start, o_md_op, o_halt, o_illegal, o_retire,
               o_state
    );

    modport slave (
        output i_instr, i_imem_ready, i_dmem_ready, i_branch_taken, i_md_done,
        input  o_imem_req, o_ir_wen, o_pc_wen, o_pc_sel, o_reg_wen,
               o_alu_src1, o_alu_src2, o_alu_op, o_dmem_ren, o_dmem_wen,
               o_wb_mux, o_md_start, o_md_op, o_halt, o_illegal, o_retire,
               o_state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// FSM sequencer for the multi-cycle RV32I core:
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with absorbing HALT
// (ebreak) and TRAP (illegal instruction / memory-wait timeout) states.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (master) : memory handshakes, datapath controls, mul/div handshake,
//                  sticky halt/illegal flags, retire pulse and debug state.
// Controls are combinational from state, md_busy and i_instr; all of them
// are forced to 0 while i_rst is high.
module multicycle_control_unit #(
    parameter int ALU_OP_WIDTH = 4,
    parameter bit ENABLE_MEXT  = 1'b0,
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
        S_WB    = 3'd4, S_HALT   = 3'd5, S_TRAP = 3'd6
    } state_t;

    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = ALU_OP_WIDTH'(4'd0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = ALU_OP_WIDTH'(4'd1);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = ALU_OP_WIDTH'(4'd2);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = ALU_OP_WIDTH'(4'd3);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = ALU_OP_WIDTH'(4'd4);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = ALU_OP_WIDTH'(4'd5);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = ALU_OP_WIDTH'(4'd6);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = ALU_OP_WIDTH'(4'd7);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = ALU_OP_WIDTH'(4'd8);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = ALU_OP_WIDTH'(4'd9);

    localparam bit TIMEOUT_EN = (MEM_WAIT_MAX != 0);
    localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    // Trap is taken on the MEM_WAIT_MAX-th consecutive not-ready cycle.
    localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_WAIT_MAX > 0) ? (MEM_WAIT_MAX - 1) : 0);

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   wait_cnt_r;
    logic            md_busy_r;

    logic [6:0] opcode_s, funct7_s;
    logic [2:0] funct3_s;
    logic is_lui_s, is_auipc_s, is_jal_s, is_jalr_s, is_branch_s, is_load_s;
    logic is_store_s, is_opimm_s, is_op_s, is_md_s, is_ebreak_s, illegal_s;
    logic [ALU_OP_WIDTH-1:0] arith_op_s;

    logic imem_req_s, ir_wen_s, pc_wen_s, reg_wen_s, alu_src1_s, alu_src2_s;
    logic dmem_ren_s, dmem_wen_s, md_start_s, halt_s, illegal_flag_s, retire_s;
    logic [1:0] pc_sel_s;
    logic [2:0] wb_mux_s, md_op_s;
    logic [ALU_OP_WIDTH-1:0] alu_op_s;
    logic md_set_s, md_clr_s, timeout_s, waiting_s;

    assign opcode_s = bus.i_instr[6:0];
    assign funct3_s = bus.i_instr[14:12];
    assign funct7_s = bus.i_instr[31:25];

    // Instruction classification and legality check
    always_comb begin
        is_lui_s = 1'b0; is_auipc_s = 1'b0; is_jal_s = 1'b0; is_jalr_s = 1'b0;
        is_branch_s = 1'b0; is_load_s = 1'b0; is_store_s = 1'b0;
        is_opimm_s = 1'b0; is_op_s = 1'b0; is_md_s = 1'b0;
        is_ebreak_s = 1'b0; illegal_s = 1'b0;
        case (opcode_s)
            OPC_LUI:    is_lui_s = 1'b1;
            OPC_AUIPC:  is_auipc_s = 1'b1;
            OPC_JAL:    is_jal_s = 1'b1;
            OPC_JALR:   if (funct3_s == 3'd0) is_jalr_s = 1'b1; else illegal_s = 1'b1;
            OPC_BRANCH: if (funct3_s == 3'd2 || funct3_s == 3'd3) illegal_s = 1'b1; else is_branch_s = 1'b1;
            OPC_LOAD:   if (funct3_s == 3'd3 || funct3_s >= 3'd6) illegal_s = 1'b1; else is_load_s = 1'b1;
            OPC_STORE:  if (funct3_s > 3'd2) illegal_s = 1'b1; else is_store_s = 1'b1;
            OPC_OPIMM: begin
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (funct3_s == 3'd1 && funct7_s != 7'd0)
                    illegal_s = 1'b1;
                else if (funct3_s == 3'd5 && funct7_s != 7'd0 && funct7_s != 7'b0100000)
                    illegal_s = 1'b1;
                else
                    is_opimm_s = 1'b1;
            end
            OPC_OP: begin
                if (funct7_s == 7'd0)
                    is_op_s = 1'b1;
                else if (funct7_s == 7'b0100000 && (funct3_s == 3'd0 || funct3_s == 3'd5))
                    is_op_s = 1'b1;
                else if (funct7_s == 7'b0000001 && ENABLE_MEXT)
                    is_md_s = 1'b1;
                else
                    illegal_s = 1'b1;
            end
            OPC_SYSTEM: if (bus.i_instr == INSTR_EBREAK) is_ebreak_s = 1'b1; else illegal_s = 1'b1;
            default:    illegal_s = 1'b1;
        endcase
    end

    // ALU op for R-type and I-type arithmetic (addi has no subtract form)
    always_comb begin
        case (funct3_s)
            3'd0:    arith_op_s = (is_op_s && funct7_s[5]) ? ALU_SUB : ALU_ADD;
            3'd1:    arith_op_s = ALU_SLL;
            3'd2:    arith_op_s = ALU_SLT;
            3'd3:    arith_op_s = ALU_SLTU;
            3'd4:    arith_op_s = ALU_XOR;
            3'd5:    arith_op_s = funct7_s[5] ? ALU_SRA : ALU_SRL;
            3'd6:    arith_op_s = ALU_OR;
            3'd7:    arith_op_s = ALU_AND;
            default: arith_op_s = ALU_ADD;
        endcase
    end

    assign timeout_s = TIMEOUT_EN && (wait_cnt_r == WAIT_LAST);
    assign waiting_s = TIMEOUT_EN &&
                       ((state_r == S_FETCH && !bus.i_imem_ready) ||
                        (state_r == S_MEM   && !bus.i_dmem_ready));

    // Next-state and per-state control decode
    always_comb begin
        state_nxt_s = state_r;
        imem_req_s = 1'b0; ir_wen_s = 1'b0; pc_wen_s = 1'b0; pc_sel_s = 2'd0;
        reg_wen_s = 1'b0; alu_src1_s = 1'b0; alu_src2_s = 1'b0; alu_op_s = ALU_ADD;
        dmem_ren_s = 1'b0; dmem_wen_s = 1'b0; wb_mux_s = 3'd0;
        md_start_s = 1'b0; md_op_s = 3'd0; halt_s = 1'b0; illegal_flag_s = 1'b0;
        retire_s = 1'b0; md_set_s = 1'b0; md_clr_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (bus.i_imem_ready) begin
                    ir_wen_s = 1'b1;
                    state_nxt_s = S_DECODE;
                end else if (timeout_s) begin
                    state_nxt_s = S_TRAP;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (illegal_s) begin
                    state_nxt_s = S_TRAP;
                end else if (is_ebreak_s) begin
                    retire_s = 1'b1;
                    state_nxt_s = S_HALT;
                end else begin
                    state_nxt_s = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_op_s || is_opimm_s) begin
                    alu_op_s = arith_op_s;
                    alu_src2_s = is_opimm_s;
                end else if (is_load_s || is_store_s || is_jalr_s) begin
                    alu_src2_s = 1'b1;
                end else if (is_auipc_s) begin
                    alu_src1_s = 1'b1;
                    alu_src2_s = 1'b1;
                end else if (is_branch_s) begin
                    // beq/bne compare by XOR, signed and unsigned by set-less-than.
                    alu_op_s = (funct3_s[2:1] == 2'b00) ? ALU_XOR :
                               (funct3_s[2:1] == 2'b10) ? ALU_SLT : ALU_SLTU;
                end else begin
                    alu_op_s = ALU_ADD;
                end

                if (is_branch_s) begin
                    pc_wen_s = 1'b1;
                    pc_sel_s = bus.i_branch_taken ? 2'd1 : 2'd0;
                    retire_s = 1'b1;
                    state_nxt_s = S_FETCH;
                end else if (is_load_s || is_store_s) begin
                    state_nxt_s = S_MEM;
                end else if (is_md_s) begin
                    md_op_s = funct3_s;
                    // A done pulse before the unit was started is not ours.
                    if (!md_busy_r) begin
                        md_start_s = 1'b1;
                        md_set_s = 1'b1;
                    end else if (bus.i_md_done) begin
                        md_clr_s = 1'b1;
                        state_nxt_s = S_WB;
                    end else begin
                        state_nxt_s = S_EXEC;
                    end
                end else begin
                    state_nxt_s = S_WB;
                end
            end
            S_MEM: begin
                dmem_ren_s = is_load_s;
                dmem_wen_s = !is_load_s;
                if (bus.i_dmem_ready) begin
                    if (is_load_s) begin
                        state_nxt_s = S_WB;
                    end else begin
                        pc_wen_s = 1'b1;
                        retire_s = 1'b1;
                        state_nxt_s = S_FETCH;
                    end
                end else if (timeout_s) begin
                    state_nxt_s = S_TRAP;
                end else begin
                    state_nxt_s = S_MEM;
                end
            end
            S_WB: begin
                reg_wen_s = !(is_store_s || is_branch_s);
                wb_mux_s = is_load_s ? 3'd1 :
                           (is_jal_s || is_jalr_s) ? 3'd2 :
                           is_lui_s ? 3'd3 :
                           is_md_s ? 3'd4 : 3'd0;
                pc_wen_s = 1'b1;
                pc_sel_s = is_jal_s ? 2'd1 : (is_jalr_s ? 2'd2 : 2'd0);
                retire_s = 1'b1;
                state_nxt_s = S_FETCH;
            end
            S_HALT:  halt_s = 1'b1;
            S_TRAP:  illegal_flag_s = 1'b1;
            default: state_nxt_s = S_FETCH;
        endcase
    end

    // State register, memory-wait counter and mul/div busy flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= '0;
            md_busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r)
                wait_cnt_r <= '0;
            else if (waiting_s)
                wait_cnt_r <= wait_cnt_r + CW'(1);
            else
                wait_cnt_r <= wait_cnt_r;
            if (md_set_s)
                md_busy_r <= 1'b1;
            else if (md_clr_s)
                md_busy_r <= 1'b0;
            else
                md_busy_r <= md_busy_r;
        end
    end

    // Reset forces every output low immediately, independent of the clock.
    assign bus.o_imem_req = imem_req_s     & ~i_rst;
    assign bus.o_ir_wen   = ir_wen_s       & ~i_rst;
    assign bus.o_pc_wen   = pc_wen_s       & ~i_rst;
    assign bus.o_pc_sel   = i_rst ? 2'd0 : pc_sel_s;
    assign bus.o_reg_wen  = reg_wen_s      & ~i_rst;
    assign bus.o_alu_src1 = alu_src1_s     & ~i_rst;
    assign bus.o_alu_src2 = alu_src2_s     & ~i_rst;
    assign bus.o_alu_op   = i_rst ? '0 : alu_op_s;
    assign bus.o_dmem_ren = dmem_ren_s     & ~i_rst;
    assign bus.o_dmem_wen = dmem_wen_s     & ~i_rst;
    assign bus.o_wb_mux   = i_rst ? 3'd0 : wb_mux_s;
    assign bus.o_md_start = md_start_s     & ~i_rst;
    assign bus.o_md_op    = i_rst ? 3'd0 : md_op_s;
    assign bus.o_halt     = halt_s         & ~i_rst;
    assign bus.o_illegal  = illegal_flag_s & ~i_rst;
    assign bus.o_retire   = retire_s       & ~i_rst;
    assign bus.o_state    = i_rst ? 3'd0 : state_r;
endmodule
